// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared EX-stage mul/div opcode encodings and sequencer state type
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_WAIT  = 3'd1,
    S_DIV_WAIT  = 3'd2,
    S_DONE      = 3'd3,
    S_DRAIN_MUL = 3'd4,
    S_DRAIN_DIV = 3'd5
  } muldiv_state_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage and mul/div unit signals seen by the sequencer
interface muldiv_ctrl_if #(
  parameter int W = 32
);
  logic           ex_valid;
  logic [2:0]     ex_op;
  logic [W-1:0]   ex_a;
  logic [W-1:0]   ex_b;
  logic           flush;
  logic           stall_ex;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;

  logic           mul_opn_valid;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_sign;
  logic           mul_res_valid;
  logic [2*W-1:0] mul_result;
  logic           mul_res_ready;

  logic           div_opn_valid;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_sign;
  logic           div_res_valid;
  logic [2*W-1:0] div_result;
  logic           div_res_ready;

  // master is the sequencer; slave is the pipeline plus the two arithmetic units
  modport master (
    input  ex_valid, ex_op, ex_a, ex_b, flush,
    output stall_ex, hi, lo,
    output mul_opn_valid, mul_a, mul_b, mul_sign, mul_res_ready,
    input  mul_res_valid, mul_result,
    output div_opn_valid, div_a, div_b, div_sign, div_res_ready,
    input  div_res_valid, div_result
  );

  modport slave (
    output ex_valid, ex_op, ex_a, ex_b, flush,
    input  stall_ex, hi, lo,
    input  mul_opn_valid, mul_a, mul_b, mul_sign, mul_res_ready,
    output mul_res_valid, mul_result,
    input  div_opn_valid, div_a, div_b, div_sign, div_res_ready,
    output div_res_valid, div_result
  );
endinterface

// File: rtl/md_holdoff.sv
// rtl/md_holdoff.sv - per-unit result holdoff down-counter with busy flag
module md_holdoff #(
  parameter int HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy
);
  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(HOLDOFF);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequences shared mul/div units for EX and owns HI/LO
module muldiv_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int W           = 32,
  parameter int RES_HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.master md
);

  muldiv_state_t r_state;
  muldiv_state_t w_next;

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_mul_a;
  logic [W-1:0] r_mul_b;
  logic [W-1:0] r_div_a;
  logic [W-1:0] r_div_b;
  logic         r_mul_opn_valid;
  logic         r_div_opn_valid;
  logic         r_mul_sign;
  logic         r_div_sign;

  logic w_live;
  logic w_op_mul;
  logic w_op_div;
  logic w_op_signed;
  logic w_div_zero;
  logic w_mul_busy;
  logic w_div_busy;
  logic w_mul_issue;
  logic w_div_issue;
  logic w_mul_acc;
  logic w_div_acc;
  logic w_move_ok;
  logic w_stall;
  logic w_mul_ready;
  logic w_div_ready;

  assign w_live      = md.ex_valid & ~md.flush;
  assign w_op_mul    = is_mul_op(md.ex_op);
  assign w_op_div    = is_div_op(md.ex_op);
  assign w_op_signed = is_signed_op(md.ex_op);
  assign w_div_zero  = (md.ex_b == '0);

  assign w_mul_issue = (r_state == S_IDLE) & w_live & w_op_mul & ~w_mul_busy;
  assign w_div_issue = (r_state == S_IDLE) & w_live & w_op_div & ~w_div_zero & ~w_div_busy;

  assign w_mul_acc = md.mul_res_valid & w_mul_ready;
  assign w_div_acc = md.div_res_valid & w_div_ready;

  // MTHI/MTLO never have to wait behind an abandoned result
  assign w_move_ok = (r_state == S_IDLE) | (r_state == S_DRAIN_MUL) | (r_state == S_DRAIN_DIV);

  md_holdoff #(.HOLDOFF(RES_HOLDOFF)) u_mul_holdoff (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_mul_acc),
    .o_busy (w_mul_busy)
  );

  md_holdoff #(.HOLDOFF(RES_HOLDOFF)) u_div_holdoff (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_div_acc),
    .o_busy (w_div_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mul_issue) begin
          w_next = S_MUL_WAIT;
        end else if (w_div_issue) begin
          w_next = S_DIV_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (w_mul_acc) begin
          if (md.flush) w_next = S_IDLE;
          else          w_next = S_DONE;
        end else if (md.flush) begin
          w_next = S_DRAIN_MUL;
        end
      end
      S_DIV_WAIT: begin
        if (w_div_acc) begin
          if (md.flush) w_next = S_IDLE;
          else          w_next = S_DONE;
        end else if (md.flush) begin
          w_next = S_DRAIN_DIV;
        end
      end
      S_DONE:      w_next = S_IDLE;
      S_DRAIN_MUL: if (w_mul_acc) w_next = S_IDLE;
      S_DRAIN_DIV: if (w_div_acc) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall     = 1'b0;
    w_mul_ready = 1'b0;
    w_div_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_live & (w_op_mul | (w_op_div & ~w_div_zero));
      end
      S_MUL_WAIT: begin
        w_stall     = ~md.flush;
        w_mul_ready = md.mul_res_valid & ~w_mul_busy;
      end
      S_DIV_WAIT: begin
        w_stall     = ~md.flush;
        w_div_ready = md.div_res_valid & ~w_div_busy;
      end
      S_DRAIN_MUL: begin
        w_stall     = w_live & (w_op_mul | w_op_div);
        w_mul_ready = md.mul_res_valid & ~w_mul_busy;
      end
      S_DRAIN_DIV: begin
        w_stall     = w_live & (w_op_mul | w_op_div);
        w_div_ready = md.div_res_valid & ~w_div_busy;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_opn_valid <= 1'b0;
      r_mul_a         <= '0;
      r_mul_b         <= '0;
      r_mul_sign      <= 1'b0;
      r_div_opn_valid <= 1'b0;
      r_div_a         <= '0;
      r_div_b         <= '0;
      r_div_sign      <= 1'b0;
    end else begin
      r_mul_opn_valid <= w_mul_issue;
      r_div_opn_valid <= w_div_issue;
      if (w_mul_issue) begin
        r_mul_a    <= md.ex_a;
        r_mul_b    <= md.ex_b;
        r_mul_sign <= w_op_signed;
      end
      if (w_div_issue) begin
        r_div_a    <= md.ex_a;
        r_div_b    <= md.ex_b;
        r_div_sign <= w_op_signed;
      end
    end
  end

  // Only a non-flushed acceptance in a WAIT state reaches HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == S_MUL_WAIT) & w_mul_acc & ~md.flush) begin
      {r_hi, r_lo} <= md.mul_result;
    end else if ((r_state == S_DIV_WAIT) & w_div_acc & ~md.flush) begin
      {r_hi, r_lo} <= md.div_result;
    end else if (w_move_ok & w_live) begin
      if (md.ex_op == MD_MTHI) r_hi <= md.ex_a;
      if (md.ex_op == MD_MTLO) r_lo <= md.ex_a;
    end
  end

  assign md.stall_ex      = w_stall;
  assign md.hi            = r_hi;
  assign md.lo            = r_lo;
  assign md.mul_opn_valid = r_mul_opn_valid;
  assign md.mul_a         = r_mul_a;
  assign md.mul_b         = r_mul_b;
  assign md.mul_sign      = r_mul_sign;
  assign md.mul_res_ready = w_mul_ready;
  assign md.div_opn_valid = r_div_opn_valid;
  assign md.div_a         = r_div_a;
  assign md.div_b         = r_div_b;
  assign md.div_sign      = r_div_sign;
  assign md.div_res_ready = w_div_ready;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl with a unit model
module tb_muldiv_ctrl;
  import cpu_defs_pkg::*;

  localparam int W    = 32;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  muldiv_ctrl_if #(.W(W)) md_bus ();

  muldiv_ctrl #(.W(W), .RES_HOLDOFF(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] q_exp[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    md_bus.ex_valid      = 1'b0;
    md_bus.ex_op         = MD_NOP;
    md_bus.ex_a          = '0;
    md_bus.ex_b          = '0;
    md_bus.flush         = 1'b0;
    md_bus.mul_res_valid = 1'b0;
    md_bus.mul_result    = '0;
    md_bus.div_res_valid = 1'b0;
    md_bus.div_result    = '0;
  endtask

  // Drives one mul/div op through EX, plays the unit, and scores HI/LO in DONE
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input bit linger, output int waited);
    bit                 is_mul;
    bit                 sgn;
    int                 n;
    logic [63:0]        res;
    logic [63:0]        exp_q;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    is_mul = (op == MD_MULT) || (op == MD_MULTU);
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    q_exp.push_back(exp);
    md_bus.ex_valid = 1'b1;
    md_bus.ex_op    = op;
    md_bus.ex_a     = a;
    md_bus.ex_b     = b;
    #1 check({name, "_entry_stall"}, md_bus.stall_ex, 1);
    n = 0;
    @(negedge clk);
    while (!(is_mul ? md_bus.mul_opn_valid : md_bus.div_opn_valid) && n < 20) begin
      n++;
      @(negedge clk);
    end
    waited = n;
    check({name, "_issue_seen"}, (n < 20), 1);
    check({name, "_sign"}, is_mul ? md_bus.mul_sign : md_bus.div_sign, sgn);
    check({name, "_operands"}, is_mul ? {md_bus.mul_a, md_bus.mul_b} : {md_bus.div_a, md_bus.div_b}, {a, b});
    check({name, "_wait_stall"}, md_bus.stall_ex, 1);
    if (is_mul) begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
        res = sa * sb;
      end else begin
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = ua * ub;
      end
    end else begin
      if (sgn) begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        res = {sr, sq};
      end else begin
        res = {a % b, a / b};
      end
    end
    repeat (lat - 1) @(negedge clk);
    if (is_mul) begin
      md_bus.mul_res_valid = 1'b1;
      md_bus.mul_result    = res;
    end else begin
      md_bus.div_res_valid = 1'b1;
      md_bus.div_result    = res;
    end
    #1 check({name, "_res_ready"}, is_mul ? md_bus.mul_res_ready : md_bus.div_res_ready, 1);
    @(negedge clk);
    check({name, "_done_stall_low"}, md_bus.stall_ex, 0);
    if (!linger) begin
      md_bus.mul_res_valid = 1'b0;
      md_bus.div_res_valid = 1'b0;
    end
    #1 check({name, "_ready_in_done"}, is_mul ? md_bus.mul_res_ready : md_bus.div_res_ready, 0);
    exp_q = q_exp.pop_front();
    check({name, "_hilo"}, {md_bus.hi, md_bus.lo}, exp_q);
    @(negedge clk);
    md_bus.mul_res_valid = 1'b0;
    md_bus.div_res_valid = 1'b0;
    md_bus.ex_valid      = 1'b0;
    md_bus.ex_op         = MD_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    md_bus.mul_res_valid = 1'b1;
    md_bus.div_res_valid = 1'b1;
    #1;
    check("rst_stall", md_bus.stall_ex, 0);
    check("rst_hilo", {md_bus.hi, md_bus.lo}, 64'h0);
    check("rst_handshakes", {md_bus.mul_opn_valid, md_bus.div_opn_valid,
                             md_bus.mul_res_ready, md_bus.div_res_ready}, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);

    run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 3, 1'b0, w);
    check("mult_issue_latency", w, 0);
    repeat (2) @(negedge clk);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1, 1'b0, w);
    repeat (2) @(negedge clk);
    run_op("div", MD_DIV, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 4, 1'b0, w);
    repeat (2) @(negedge clk);

    // DIVU by zero: no issue, no stall, HI/LO untouched
    md_bus.ex_valid = 1'b1;
    md_bus.ex_op    = MD_DIVU;
    md_bus.ex_a     = 32'd5;
    md_bus.ex_b     = 32'd0;
    #1 check("divz_stall", md_bus.stall_ex, 0);
    @(negedge clk);
    check("divz_no_issue", md_bus.div_opn_valid, 0);
    check("divz_hilo", {md_bus.hi, md_bus.lo}, {32'h1, 32'hFFFF_FFFD});

    md_bus.ex_op = MD_MTLO;
    md_bus.ex_a  = 32'h0000_CAFE;
    #1 check("mtlo_stall", md_bus.stall_ex, 0);
    @(negedge clk);
    check("mtlo_hilo", {md_bus.hi, md_bus.lo}, {32'h1, 32'h0000_CAFE});

    md_bus.ex_op = MD_MTHI;
    md_bus.ex_a  = 32'h0000_DEAD;
    md_bus.flush = 1'b1;
    @(negedge clk);
    check("flushed_mthi", md_bus.hi, 32'h1);
    idle_inputs();
    @(negedge clk);

    // Flush one cycle after issue: drain and discard
    md_bus.ex_valid = 1'b1;
    md_bus.ex_op    = MD_MULT;
    md_bus.ex_a     = 32'd5;
    md_bus.ex_b     = 32'd6;
    @(negedge clk);
    check("fl_issue", md_bus.mul_opn_valid, 1);
    md_bus.flush = 1'b1;
    #1 check("fl_wait_stall", md_bus.stall_ex, 0);
    @(negedge clk);
    md_bus.flush    = 1'b0;
    md_bus.ex_valid = 1'b0;
    #1 check("fl_drain_stall", md_bus.stall_ex, 0);
    @(negedge clk);
    md_bus.mul_res_valid = 1'b1;
    md_bus.mul_result    = 64'd30;
    #1 check("fl_drain_ready", md_bus.mul_res_ready, 1);
    @(negedge clk);
    md_bus.mul_res_valid = 1'b0;
    check("fl_hilo_kept", {md_bus.hi, md_bus.lo}, {32'h1, 32'h0000_CAFE});
    repeat (2) @(negedge clk);

    // Back-to-back with the first result lingering through DONE
    run_op("b2b0", MD_MULT, 32'd3, 32'd4, 64'd12, 2, 1'b1, w);
    check("b2b0_latency", w, 0);
    run_op("b2b1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 2, 1'b0, w);
    check("b2b1_holdoff_delay", w, HOLD - 1);
    repeat (2) @(negedge clk);

    // MTHI while a flushed DIV drains
    md_bus.ex_valid = 1'b1;
    md_bus.ex_op    = MD_DIV;
    md_bus.ex_a     = 32'd9;
    md_bus.ex_b     = 32'd3;
    @(negedge clk);
    check("dr_issue", md_bus.div_opn_valid, 1);
    md_bus.flush = 1'b1;
    @(negedge clk);
    md_bus.flush = 1'b0;
    md_bus.ex_op = MD_MTHI;
    md_bus.ex_a  = 32'h0000_1234;
    #1 check("dr_mthi_stall", md_bus.stall_ex, 0);
    @(negedge clk);
    check("dr_mthi_hi", md_bus.hi, 32'h0000_1234);
    md_bus.ex_op = MD_MULT;
    md_bus.ex_a  = 32'd1;
    md_bus.ex_b  = 32'd1;
    #1 check("dr_newop_stall", md_bus.stall_ex, 1);
    md_bus.ex_valid      = 1'b0;
    md_bus.div_res_valid = 1'b1;
    md_bus.div_result    = {32'd0, 32'd3};
    #1 check("dr_ready", md_bus.div_res_ready, 1);
    @(negedge clk);
    md_bus.div_res_valid = 1'b0;
    check("dr_hilo", {md_bus.hi, md_bus.lo}, {32'h0000_1234, 32'h1});
    repeat (2) @(negedge clk);

    // Reset while waiting on the multiplier
    md_bus.ex_valid = 1'b1;
    md_bus.ex_op    = MD_MULT;
    md_bus.ex_a     = 32'd2;
    md_bus.ex_b     = 32'd3;
    @(negedge clk);
    check("rw_issue", md_bus.mul_opn_valid, 1);
    rst                  = 1'b1;
    md_bus.ex_valid      = 1'b0;
    md_bus.mul_res_valid = 1'b1;
    md_bus.mul_result    = 64'd6;
    @(negedge clk);
    check("rw_stall", md_bus.stall_ex, 0);
    check("rw_hilo", {md_bus.hi, md_bus.lo}, 64'h0);
    check("rw_handshakes", {md_bus.mul_opn_valid, md_bus.mul_res_ready}, 0);
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
